tmds_timing_sequencer: RTL
==========================

// Module: tmds_timing_sequencer
// PURPOSE
//  Raster timing controller for the three TMDS channel encoders. Generates DE, HSync and VSync
//  (driven to the encoders' DE and C0/C1 inputs) plus pixel coordinates and a one-cycle-early
//  pixel request for the frame-buffer fetch path. Supports frame-aligned start/stop via Enable.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch, in pixels
//  H_SYNC    96   HSync width, in pixels
//  H_BP      48   horizontal back porch, in pixels
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch, in lines
//  V_SYNC    2    VSync width, in lines
//  V_BP      33   vertical back porch, in lines
//  SYNC_POL  0    active level of HSync/VSync (0 = active-low)
// PORTS
//  PixClk     in   1   pixel clock; all logic on rising edge
//  Reset      in   1   synchronous reset, active-high
//  Enable     in   1   run request; sampled only at frame boundary / in IDLE
//  DE         out  1   data enable (active video)
//  HSync      out  1   horizontal sync, level per SYNC_POL
//  VSync      out  1   vertical sync, level per SYNC_POL
//  PixReq     out  1   high in the cycle immediately before every DE=1 cycle
//  X          out  12  pixel column, valid when DE=1, else 0
//  Y          out  11  pixel line, valid when DE=1, else 0
//  LineStart  out  1   one-cycle pulse when HCnt=0 (every line, active or blank)
//  FrameStart out  1   one-cycle pulse when HCnt=0 and VCnt=0
// BEHAVIOUR
//  - H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Counters HCnt [0,H_TOTAL-1], VCnt [0,V_TOTAL-1].
//  - States: IDLE, RUN. Reset -> IDLE: HCnt=VCnt=0; DE=PixReq=LineStart=FrameStart=0; X=Y=0;
//    HSync=VSync=~SYNC_POL. Reset wins over every other input, including mid-line/mid-frame.
//  - IDLE: outputs held at reset values except PixReq. If Enable=1, next edge -> RUN with HCnt=VCnt=0;
//    PixReq=1 in the IDLE cycle where Enable=1 (the first visible pixel follows).
//  - RUN: HCnt increments each cycle; at H_TOTAL-1 wraps to 0 and VCnt increments; VCnt wraps
//    at V_TOTAL-1. At the last cycle of a frame (HCnt=H_TOTAL-1, VCnt=V_TOTAL-1): Enable=1 -> wrap
//    to (0,0) and stay RUN; Enable=0 -> IDLE. Enable changes mid-frame have no effect.
//  - All outputs registered and decoded from the counter values present in the same cycle (no skew
//    between DE, X, Y, syncs). Zero-latency alignment: cycle with HCnt=h,VCnt=v shows decode(h,v).
//  - DE=1 iff HCnt<H_ACTIVE and VCnt<V_ACTIVE; then X=HCnt, Y=VCnt.
//  - HSync active iff H_ACTIVE+H_FP <= HCnt < H_ACTIVE+H_FP+H_SYNC, on every line incl. vertical blank.
//  - VSync active iff V_ACTIVE+V_FP <= VCnt < V_ACTIVE+V_FP+V_SYNC; edges therefore coincide with HCnt=0.
//  - PixReq = DE value of the following cycle (lookahead computed from next-state counters, including
//    wrap and IDLE->RUN transitions); PixReq=0 in the last cycle before IDLE.
//  - Arithmetic: counter widths 12/11 bits; totals must fit (checked by elaboration-time assertion).
// TESTING
//  - Reset held 4 cycles, Enable=1 -> DE=0, HSync=VSync=1, X=Y=0 during reset; PixReq=1 first
//    cycle after reset release; next cycle DE=1, X=0, Y=0, FrameStart=1, LineStart=1.
//  - Defaults, one line: DE high 640 consecutive cycles (X 0..639), HSync low for cycles 656..751
//    of the line (96 cycles), line period 800 cycles, LineStart period 800.
//  - Full frame: FrameStart period 420000 cycles; VSync low exactly 1600 cycles starting at the
//    HCnt=0 of line 490; DE count per frame 307200.
//  - Enable dropped at line 100 -> frame completes unchanged; after cycle (799,524) enter IDLE,
//    outputs idle; Enable re-asserted 50 cycles later -> PixReq then DE=1, X=0, Y=0 next cycle.
//  - Reset asserted at HCnt=300,VCnt=200 -> next cycle all outputs at reset values; restart at (0,0).
//  - Every cycle: checker asserts PixReq(t)==DE(t+1) and X/Y==0 whenever DE=0.

Source files
------------

// File: rtl/tmds_timing_sequencer_if.sv
// Raster timing bundle between the sequencer and the TMDS encoder / frame-buffer fetch side.
// The sequencer drives everything except Enable, which comes from the control side.
interface tmds_timing_sequencer_if;
  logic        Enable;
  logic        DE;
  logic        HSync;
  logic        VSync;
  logic        PixReq;
  logic [11:0] X;
  logic [10:0] Y;
  logic        LineStart;
  logic        FrameStart;

  modport master (
    input  Enable,
    output DE, HSync, VSync, PixReq, X, Y, LineStart, FrameStart
  );

  modport slave (
    output Enable,
    input  DE, HSync, VSync, PixReq, X, Y, LineStart, FrameStart
  );
endinterface

// File: rtl/tmds_timing_sequencer.sv
// Raster timing controller: H/V counters with frame-aligned start/stop, registered DE/sync/X/Y
// decoded from the counter values of the same cycle, and a one-cycle-early pixel request.
module tmds_timing_sequencer #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                          PixClk,
  input  logic                          Reset,
  tmds_timing_sequencer_if.master       vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = V_ACTIVE + V_FP + V_SYNC;
  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);

  if ((H_TOTAL > 4096) || (V_TOTAL > 2048) || (H_ACTIVE < 1) || (V_ACTIVE < 1)) begin : g_bad_totals
    $error("tmds_timing_sequencer: raster totals do not fit the 12/11-bit counters");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_reg, state_next;
  logic [11:0] h_cnt_reg, h_next, h_after;
  logic [10:0] v_cnt_reg, v_next, v_after;

  logic        de_reg, hsync_reg, vsync_reg, pix_la_reg;
  logic        line_start_reg, frame_start_reg;
  logic [11:0] x_reg;
  logic [10:0] y_reg;

  logic        n_de, n_hs_act, n_vs_act, a_de, frame_end;

  // Next-cycle counter position, then the position one cycle beyond it for the PixReq lookahead.
  always_comb begin
    state_next = state_reg;
    h_next     = h_cnt_reg;
    v_next     = v_cnt_reg;
    if (state_reg == IDLE) begin
      h_next     = '0;
      v_next     = '0;
      state_next = vid.Enable ? RUN : IDLE;
    end else if (h_cnt_reg == H_LAST) begin
      h_next = '0;
      if (v_cnt_reg == V_LAST) begin
        v_next     = '0;
        state_next = vid.Enable ? RUN : IDLE;
      end else begin
        v_next = v_cnt_reg + 11'd1;
      end
    end else begin
      h_next = h_cnt_reg + 12'd1;
    end

    h_after = (h_next == H_LAST) ? '0 : h_next + 12'd1;
    v_after = v_next;
    if (h_next == H_LAST) begin
      v_after = (v_next == V_LAST) ? '0 : v_next + 11'd1;
    end
  end

  assign n_de     = (int'(h_next) < H_ACTIVE) && (int'(v_next) < V_ACTIVE);
  assign n_hs_act = (int'(h_next) >= HS_BEG) && (int'(h_next) < HS_END);
  assign n_vs_act = (int'(v_next) >= VS_BEG) && (int'(v_next) < VS_END);
  assign a_de     = (int'(h_after) < H_ACTIVE) && (int'(v_after) < V_ACTIVE);

  always_ff @(posedge PixClk) begin
    if (Reset) begin
      state_reg       <= IDLE;
      h_cnt_reg       <= '0;
      v_cnt_reg       <= '0;
      de_reg          <= 1'b0;
      x_reg           <= '0;
      y_reg           <= '0;
      hsync_reg       <= ~SYNC_POL;
      vsync_reg       <= ~SYNC_POL;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      pix_la_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      h_cnt_reg <= h_next;
      v_cnt_reg <= v_next;
      if (state_next == RUN) begin
        de_reg          <= n_de;
        x_reg           <= n_de ? h_next : '0;
        y_reg           <= n_de ? v_next : '0;
        hsync_reg       <= n_hs_act ? SYNC_POL : ~SYNC_POL;
        vsync_reg       <= n_vs_act ? SYNC_POL : ~SYNC_POL;
        line_start_reg  <= (h_next == '0);
        frame_start_reg <= (h_next == '0) && (v_next == '0);
        pix_la_reg      <= a_de;
      end else begin
        de_reg          <= 1'b0;
        x_reg           <= '0;
        y_reg           <= '0;
        hsync_reg       <= ~SYNC_POL;
        vsync_reg       <= ~SYNC_POL;
        line_start_reg  <= 1'b0;
        frame_start_reg <= 1'b0;
        pix_la_reg      <= 1'b0;
      end
    end
  end

  // Whether the next cycle is pixel (0,0) depends on Enable in this very cycle, both in IDLE and
  // at the last cycle of a frame, so PixReq follows Enable there instead of the registered lookahead.
  assign frame_end = (state_reg == RUN) && (h_cnt_reg == H_LAST) && (v_cnt_reg == V_LAST);

  assign vid.PixReq     = ~Reset & (((state_reg == IDLE) || frame_end) ? vid.Enable : pix_la_reg);
  assign vid.DE         = de_reg;
  assign vid.X          = x_reg;
  assign vid.Y          = y_reg;
  assign vid.HSync      = hsync_reg;
  assign vid.VSync      = vsync_reg;
  assign vid.LineStart  = line_start_reg;
  assign vid.FrameStart = frame_start_reg;

endmodule
